// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Multi-cycle fetch/execute sequencer for the LEGv8 datapath.
//            Owns the architectural PC, issues instruction-memory requests,
//            latches the fetched word, and commits PC+step or the branch
//            target once the datapath reports completion.
//            Optional macro PC_SEQ_STATS_EN adds RetiredCount / TakenCount.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] PC_STEP      = 64'd4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    input  logic        ExecDone,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    input  logic [63:0] SignExtImm64,
    output logic [63:0] CurrentPC,
    output logic        Fault
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [31:0] RetiredCount,
    output logic [31:0] TakenCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    logic        taken;
    logic [63:0] target;
    logic [63:0] seq_pc;
    logic [63:0] next_pc;
    logic        misaligned;

    // The fetch address is the architectural PC itself, never a copy.
    assign ImemAddr = CurrentPC;

    // Next-PC selection; only meaningful in the ExecDone cycle of EXEC.
    always_comb begin
        taken      = Uncondbranch | (Branch & ALUZero);
        target     = CurrentPC + (SignExtImm64 << 2);
        seq_pc     = CurrentPC + PC_STEP;
        next_pc    = taken ? target : seq_pc;
        misaligned = (next_pc[1:0] != 2'b00);
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_IDLE;
            CurrentPC   <= RESET_VECTOR;
            ImemReq     <= 1'b0;
            InstrValid  <= 1'b0;
            Instruction <= 32'h0;
            Fault       <= 1'b0;
`ifdef PC_SEQ_STATS_EN
            RetiredCount <= 32'h0;
            TakenCount   <= 32'h0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!Stall) begin
                        state   <= S_FETCH;
                        ImemReq <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Request stays up until acknowledged; Stall has no say here.
                    if (ImemAck) begin
                        Instruction <= ImemData;
                        ImemReq     <= 1'b0;
                        InstrValid  <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ExecDone) begin
                        InstrValid <= 1'b0;
                        if (misaligned) begin
                            // PC is left pointing at the offending instruction.
                            Fault <= 1'b1;
                            state <= S_FAULT;
                        end else begin
                            CurrentPC <= next_pc;
`ifdef PC_SEQ_STATS_EN
                            RetiredCount <= RetiredCount + 32'd1;
                            if (taken) begin
                                TakenCount <= TakenCount + 32'd1;
                            end
`endif
                            if (!Stall) begin
                                state   <= S_FETCH;
                                ImemReq <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                S_FAULT: begin
                    // Sticky until Reset.
                    Fault      <= 1'b1;
                    ImemReq    <= 1'b0;
                    InstrValid <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
